hsi_frame_receiver: RTL and testbench

// Downstream capture stage for the HSI serial link (HSCK/HSDATA). Recovers

---
 rtl/hsi_frame_receiver.sv | 189 ++++++++++++++++++
 tb/tb_hsi_frame_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hsi_frame_receiver.sv
// hsi_frame_receiver
//   Capture stage for the HSI serial link. Synchronises HSCK/HSDATA into the
//   system clock domain, shifts in MSB-first frames, checks bit count and pad
//   bit, and hands each 16-bit payload to a valid/ready output register.
//   Also keeps a good-frame counter and sticky error flags.
//
// Ports
//   clock        system clock (HSCK period must be >= 2 clocks)
//   reset        asynchronous, active-high
//   enable       1 = receive, 0 = abort any frame and return to IDLE
//   hsck_pol     1 = HSCK is inverted on the wire
//   HSCK/HSDATA  serial clock and data (data changes on HSCK rising edge)
//   data_out     received payload
//   data_valid   data_out holds an unconsumed word
//   data_ready   consumer accepts when data_valid & data_ready
//   frame_count  good frames received (wraps)
//   frame_err    sticky: bad bit count or pad bit set
//   overflow     sticky: good frame dropped because output was full
//   clear_flags  pulse clears frame_err, overflow, frame_count
//   busy         1 while the receiver is not IDLE
module hsi_frame_receiver #(
  parameter int FRAME_BITS  = 17,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  hsck_pol,
  input  logic                  HSCK,
  input  logic                  HSDATA,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [15:0]           frame_count,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  clear_flags,
  output logic                  busy
);

  localparam int BW = $clog2(FRAME_BITS + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [SYNC_STAGES-1:0]  r_sck_sync;
  logic [SYNC_STAGES:0]    r_dat_sync;   // one stage longer: bit sampled before HSCK rose
  logic                    r_sck_d;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [BW-1:0]           r_bit_cnt;
  logic [GW-1:0]           r_gap_cnt;

  logic w_sck_s;
  logic w_bit;
  logic w_rise;
  logic w_shift;
  logic w_gap_inc;
  logic w_clr;
  logic w_frame_ok;
  logic w_good;
  logic w_bad;
  logic w_accept;
  logic w_load;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_bit    = r_dat_sync[SYNC_STAGES];
  assign w_rise   = w_sck_s & ~r_sck_d;
  assign w_accept = data_valid & data_ready;
  assign w_load   = w_good & (~data_valid | w_accept);

  // Synchronisers and edge-detect delay.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_dat_sync <= '0;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], HSCK ^ hsck_pol};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-1:0], HSDATA};
      r_sck_d    <= w_sck_s;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_rise) w_next = SHIFT;
        SHIFT:   if (!w_rise && r_gap_cnt == GW'(GAP_CYCLES - 1)) w_next = CHECK;
        CHECK:   w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM outputs and datapath controls
  always_comb begin
    w_shift    = 1'b0;
    w_gap_inc  = 1'b0;
    w_clr      = 1'b0;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    busy       = (r_state != IDLE);
    w_frame_ok = (r_bit_cnt == BW'(FRAME_BITS)) && !r_shreg[FRAME_BITS-1];
    if (!enable) begin
      // abort silently: partial frame is discarded without a flag
      w_clr = 1'b0 | 1'b1;
    end else begin
      case (r_state)
        IDLE:  w_shift = w_rise;
        SHIFT: begin
          w_shift   = w_rise;
          w_gap_inc = ~w_rise;
        end
        CHECK: begin
          w_clr  = 1'b1;
          w_good = w_frame_ok;
          w_bad  = ~w_frame_ok;
        end
        default: w_clr = 1'b1;
      endcase
    end
  end

  // Shift register, bit counter and gap counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (w_clr) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (w_shift) begin
      r_shreg   <= {r_shreg[FRAME_BITS-2:0], w_bit};
      r_gap_cnt <= '0;
      // saturate one past a legal frame so overlong frames can never alias
      if (r_state == IDLE)                         r_bit_cnt <= BW'(1);
      else if (r_bit_cnt != BW'(FRAME_BITS + 1))   r_bit_cnt <= r_bit_cnt + 1'b1;
    end else if (w_gap_inc) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  // Output register, counter and sticky flags (a set event beats clear_flags)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_count <= '0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (w_load) begin
        data_out   <= r_shreg[DATA_WIDTH-1:0];
        data_valid <= 1'b1;
      end else if (w_accept) begin
        data_valid <= 1'b0;
      end

      if (clear_flags) frame_count <= w_good ? 16'd1 : 16'd0;
      else if (w_good) frame_count <= frame_count + 16'd1;

      if (w_bad)            frame_err <= 1'b1;
      else if (clear_flags) frame_err <= 1'b0;

      if (w_good && !w_load) overflow <= 1'b1;
      else if (clear_flags)  overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hsi_frame_receiver.sv
// tb_hsi_frame_receiver
//   Directed bench for hsi_frame_receiver: drives HSCK/HSDATA frames bit by
//   bit (HSCK period 2 clocks) and compares outputs with hand-computed values.
module tb_hsi_frame_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        hsck_pol = 1'b0;
  logic        HSCK = 1'b0;
  logic        HSDATA = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic [15:0] frame_count;
  logic        frame_err;
  logic        overflow;
  logic        clear_flags = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_bad    = 0;

  hsi_frame_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .hsck_pol    (hsck_pol),
    .HSCK        (HSCK),
    .HSDATA      (HSDATA),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_count (frame_count),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clear_flags (clear_flags),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Sends the low n bits of word, MSB first. HSDATA is held through each
  // low/high HSCK phase; the line is left at its idle level afterwards.
  task automatic send(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      HSDATA = word[i];
      HSCK   = hsck_pol;
      @(negedge clock);
      HSCK   = ~hsck_pol;
      @(negedge clock);
    end
    HSCK   = hsck_pol;
    HSDATA = 1'b0;
  endtask

  // Waits (bounded) for data_valid; a timeout is reported as a failed check.
  task automatic expect_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      seen = data_valid;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_data",  {16'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
    check("rst_flags", {30'd0, frame_err, overflow}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    wait_cycles(2);

    // 1: single frame 0xA5C3, consumer always ready
    data_ready = 1'b1;
    send({15'd0, 1'b0, 16'hA5C3}, 17);
    expect_valid("t1_valid_seen");
    check("t1_data",  {16'd0, data_out}, 32'h0000_A5C3);
    check("t1_busy",  {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("t1_one_cycle", {31'd0, data_valid}, 32'd0);
    check("t1_count", {16'd0, frame_count}, 32'd1);
    check("t1_flags", {30'd0, frame_err, overflow}, 32'd0);

    // 2: three frames with the consumer stalled
    data_ready = 1'b0;
    pulse_clear();
    check("t2_count_clr", {16'd0, frame_count}, 32'd0);
    send(32'h0000_0003, 17);
    expect_valid("t2_valid_seen");
    check("t2_data1", {16'd0, data_out}, 32'h0003);
    check("t2_ovf1",  {31'd0, overflow}, 32'd0);
    wait_cycles(2);
    send(32'h0000_0002, 17);
    wait_cycles(14);
    check("t2_data2", {16'd0, data_out}, 32'h0003);
    check("t2_ovf2",  {31'd0, overflow}, 32'd1);
    check("t2_valid2", {31'd0, data_valid}, 32'd1);
    send(32'h0000_0001, 17);
    wait_cycles(14);
    check("t2_data3",  {16'd0, data_out}, 32'h0003);
    check("t2_count3", {16'd0, frame_count}, 32'd3);
    check("t2_err",    {31'd0, frame_err}, 32'd0);
    data_ready = 1'b1;
    @(negedge clock);
    check("t2_drain", {31'd0, data_valid}, 32'd0);
    pulse_clear();
    check("t2_ovf_clr", {31'd0, overflow}, 32'd0);

    // 3: short (16-bit) then long (18-bit) frames
    send(32'h0000_1234, 16);
    wait_cycles(14);
    check("t3_err16",   {31'd0, frame_err}, 32'd1);
    check("t3_valid16", {31'd0, data_valid}, 32'd0);
    check("t3_count16", {16'd0, frame_count}, 32'd0);
    pulse_clear();
    check("t3_err_clr", {31'd0, frame_err}, 32'd0);
    send(32'h0000_1234, 18);
    wait_cycles(14);
    check("t3_err18",   {31'd0, frame_err}, 32'd1);
    check("t3_valid18", {31'd0, data_valid}, 32'd0);
    check("t3_count18", {16'd0, frame_count}, 32'd0);
    pulse_clear();

    // 4: correct length but pad bit set
    send({15'd0, 1'b1, 16'h00FF}, 17);
    wait_cycles(14);
    check("t4_err",   {31'd0, frame_err}, 32'd1);
    check("t4_valid", {31'd0, data_valid}, 32'd0);
    check("t4_ovf",   {31'd0, overflow}, 32'd0);
    pulse_clear();

    // 5: inverted HSCK; then an aborted partial frame
    hsck_pol = 1'b1;
    HSCK     = 1'b1;
    wait_cycles(4);
    send({15'd0, 1'b0, 16'hFFFF}, 17);
    expect_valid("t5_valid_seen");
    check("t5_data",  {16'd0, data_out}, 32'h0000_FFFF);
    check("t5_err",   {31'd0, frame_err}, 32'd0);
    check("t5_count", {16'd0, frame_count}, 32'd1);
    send(32'h0001_5A5A >> 8, 9);
    wait_cycles(2);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    wait_cycles(5);
    check("t5_busy_abort", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_cycles(14);
    check("t5_abort_flags", {30'd0, frame_err, overflow}, 32'd0);
    check("t5_abort_valid", {31'd0, data_valid}, 32'd0);
    check("t5_abort_data",  {16'd0, data_out}, 32'h0000_FFFF);
    HSCK     = 1'b0;
    hsck_pol = 1'b0;
    wait_cycles(4);

    // 6: reset in the middle of a frame, then a clean frame
    send(32'h0000_1234 >> 9, 8);
    reset = 1'b1;
    #1;
    check("t6_rst_data",  {16'd0, data_out}, 32'd0);
    check("t6_rst_count", {16'd0, frame_count}, 32'd0);
    check("t6_rst_busy",  {31'd0, busy}, 32'd0);
    check("t6_rst_flags", {29'd0, frame_err, overflow, data_valid}, 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
    send({15'd0, 1'b0, 16'h1234}, 17);
    expect_valid("t6_valid_seen");
    check("t6_data",  {16'd0, data_out}, 32'h0000_1234);
    check("t6_count", {16'd0, frame_count}, 32'd1);
    check("t6_flags", {30'd0, frame_err, overflow}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
